output_writeback_controller: RTL

OUTPUT_WRITEBACK_CONTROLLER -- requirements
Module: output_writeback_controller

---
 rtl/output_writeback_controller.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/output_writeback_controller.sv
// Output writeback controller: takes one batch of SA_HEIGHT systolic-array
// results per compute_done pulse and streams them, one word per accepted
// write, into the output SRAM in raster order starting at a base address.
module output_writeback_controller #(
    parameter int SA_HEIGHT  = 4,
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16,
    localparam int SA_BITS   = (SA_HEIGHT > 1) ? $clog2(SA_HEIGHT) : 1
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_en,
    input  logic                             i_reg_clear,
    input  logic                             i_compute_done,
    input  logic [ADDR_WIDTH-1:0]            i_start_addr,
    input  logic [ADDR_WIDTH-1:0]            i_o_size,
    input  logic [SA_HEIGHT*DATA_WIDTH-1:0]  i_sa_data,
    input  logic                             i_wr_ready,
    output logic                             o_wr_en,
    output logic [ADDR_WIDTH-1:0]            o_wr_addr,
    output logic [DATA_WIDTH-1:0]            o_wr_data,
    output logic [SA_BITS-1:0]               o_row_number,
    output logic [ADDR_WIDTH-1:0]            o_o_x,
    output logic [ADDR_WIDTH-1:0]            o_o_y,
    output logic                             o_busy,
    output logic                             o_overrun,
    output logic                             o_done
);

    // Pixel counter and total are twice the address width so size*size
    // never truncates.
    localparam int PW = 2 * ADDR_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0] start_q, start_d;
    logic [ADDR_WIDTH-1:0] size_q,  size_d;
    logic [ADDR_WIDTH-1:0] x_q,     x_d;
    logic [ADDR_WIDTH-1:0] y_q,     y_d;
    logic [PW-1:0]         pix_q,   pix_d;
    logic [PW-1:0]         total_q, total_d;
    logic [SA_BITS-1:0]    row_q,   row_d;
    logic                  overrun_q, overrun_d;
    logic [DATA_WIDTH-1:0] buf_q [SA_HEIGHT];
    logic [DATA_WIDTH-1:0] buf_d [SA_HEIGHT];

    logic [PW-1:0] pix_inc;
    logic          last_pix;
    logic          last_row;
    logic          last_col;

    assign pix_inc  = pix_q + PW'(1);
    assign last_pix = (pix_inc == total_q);
    assign last_row = (row_q == SA_BITS'(SA_HEIGHT - 1));
    assign last_col = (x_q == size_q - ADDR_WIDTH'(1));

    // State register; reset forces IDLE immediately.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; clear overrides every other condition.
    always_comb begin
        state_d = state_q;
        if (i_reg_clear) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_en) begin
                        state_d = (i_o_size == '0) ? S_DONE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (i_compute_done) begin
                        state_d = S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (i_wr_ready) begin
                        if (last_pix) begin
                            state_d = S_DONE;
                        end else if (last_row) begin
                            state_d = S_WAIT;
                        end else begin
                            state_d = S_WRITE;
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Datapath next-state: configuration latch, batch capture and the
    // pix/x/y/row counters that advance only on an accepted write.
    always_comb begin
        start_d   = start_q;
        size_d    = size_q;
        total_d   = total_q;
        pix_d     = pix_q;
        x_d       = x_q;
        y_d       = y_q;
        row_d     = row_q;
        overrun_d = overrun_q;
        buf_d     = buf_q;

        if (i_reg_clear) begin
            pix_d     = '0;
            x_d       = '0;
            y_d       = '0;
            row_d     = '0;
            overrun_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_en) begin
                        start_d = i_start_addr;
                        size_d  = i_o_size;
                        total_d = PW'(i_o_size) * PW'(i_o_size);
                        pix_d   = '0;
                        x_d     = '0;
                        y_d     = '0;
                        row_d   = '0;
                    end
                end
                S_WAIT: begin
                    if (i_compute_done) begin
                        for (int unsigned r = 0; r < SA_HEIGHT; r++) begin
                            buf_d[r] = i_sa_data[r*DATA_WIDTH +: DATA_WIDTH];
                        end
                        row_d = '0;
                    end
                end
                S_WRITE: begin
                    if (i_compute_done) begin
                        overrun_d = 1'b1;
                    end
                    if (i_wr_ready) begin
                        pix_d = pix_inc;
                        row_d = last_row ? '0 : row_q + SA_BITS'(1);
                        if (last_col) begin
                            x_d = '0;
                            y_d = y_q + ADDR_WIDTH'(1);
                        end else begin
                            x_d = x_q + ADDR_WIDTH'(1);
                        end
                    end
                end
                S_DONE: begin
                    if (i_compute_done) begin
                        overrun_d = 1'b1;
                    end
                end
                default: begin
                    overrun_d = overrun_q;
                end
            endcase
        end
    end

    // Datapath registers; reset clears counters, configuration and buffer.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            start_q   <= '0;
            size_q    <= '0;
            total_q   <= '0;
            pix_q     <= '0;
            x_q       <= '0;
            y_q       <= '0;
            row_q     <= '0;
            overrun_q <= 1'b0;
            for (int unsigned r = 0; r < SA_HEIGHT; r++) begin
                buf_q[r] <= '0;
            end
        end else begin
            start_q   <= start_d;
            size_q    <= size_d;
            total_q   <= total_d;
            pix_q     <= pix_d;
            x_q       <= x_d;
            y_q       <= y_d;
            row_q     <= row_d;
            overrun_q <= overrun_d;
            buf_q     <= buf_d;
        end
    end

    // Output decode from state and registers only; the address is base plus
    // the low bits of the pixel counter, wrapping naturally.
    always_comb begin
        o_wr_en      = 1'b0;
        o_wr_addr    = '0;
        o_wr_data    = '0;
        o_o_x        = '0;
        o_o_y        = '0;
        o_row_number = row_q;
        o_busy       = (state_q == S_WAIT) || (state_q == S_WRITE);
        o_done       = (state_q == S_DONE);
        o_overrun    = overrun_q;
        if (state_q == S_WRITE) begin
            o_wr_en   = 1'b1;
            o_wr_addr = start_q + pix_q[ADDR_WIDTH-1:0];
            o_wr_data = buf_q[row_q];
            o_o_x     = x_q;
            o_o_y     = y_q;
        end
    end

endmodule
